sbox_share_ctrl: RTL and testbench
==================================

# sbox_share_ctrl

Controller that time-shares one bank of four `sbox` instances (32 bits per cycle) between two requesters: the round datapath (SubBytes on a 128-bit state) and the key expansion (SubWord on a 32-bit word). It sits between the AES round logic and key schedule, replacing sixteen dedicated S-boxes with four. Jobs are accepted through valid/ready handshakes, sequenced by an FSM, and returned as registered results with a one-cycle valid pulse.

## Interface
- `DATA_W`, 128: SubBytes state width (fixed; 4 words).
- `WORD_W`, 32: SubWord / bank width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `d_valid` in 1: SubBytes request.
- `d_ready` out 1: SubBytes request accepted when `d_valid && d_ready`.
- `d_in` in 128: state to substitute, byte 0 at [127:120].
- `d_out_valid` out 1: one-cycle pulse, `d_out` valid.
- `d_out` out 128: substituted state.
- `k_valid` in 1: SubWord request.
- `k_ready` out 1: SubWord request accepted when `k_valid && k_ready`.
- `k_in` in 32: word to substitute.
- `k_out_valid` out 1: one-cycle pulse, `k_out` valid.
- `k_out` out 32: substituted word.
- `busy` out 1: FSM not in IDLE.

## Operation
- FSM states: IDLE, DATA, KEY. 2-bit word counter `cnt` is used in DATA.
- IDLE: `d_ready`/`k_ready` assert only here, and at most one is high. Grant follows the arbitration policy in Configuration. Accepting a request registers its input and moves to DATA (cnt=0) or KEY.
- DATA: the bank's input is captured word `cnt`, where word 0 = [127:96]. The bank output is written into the same word slot of `d_out` at the clock edge, and `cnt` increments. At cnt=3 the FSM returns to IDLE and `d_out_valid` pulses.
- KEY: the bank's input is the captured `k_in`. `k_out` is written at the edge, the FSM returns to IDLE and `k_out_valid` pulses.
- Jobs are atomic. A pending key request never pre-empts a data job in progress, and the reverse also holds.
- `d_out`/`k_out` hold their last value until the next completion of the same job type.
- Inputs are sampled only at acceptance. Requesters may change `d_in`/`k_in` freely afterwards.
- No output backpressure. The consumer must capture on the valid pulse.
- Reset values: state IDLE, cnt 0, `d_out` 0, `k_out` 0, both out-valids 0, `busy` 0, round-robin pointer = "key served last" (so data wins first).
- `rst` asserted mid-job aborts the job: no out-valid is emitted and the partial `d_out` is cleared.

## Timing
- Acceptance at edge E0. Data result is registered at E4, and `d_out_valid` is high in the cycle after E4 (latency 4).
- Key: result registered at E1, `k_out_valid` high in the cycle after E1 (latency 1).
- `d_out_valid`/`k_out_valid` coincide with the return to IDLE. A new request can be accepted in that same cycle, so the data job period is 5 cycles and the key job period is 2.
- S-box lookup is combinational inside the cycle. There is no pipeline register before the output register.

## Configuration
- `SBOX_KEY_PRIO_EN` defined: when both valids are high in IDLE, the key request always wins (strict priority). The round-robin pointer is not implemented.
- Not defined: round-robin. On a tie, grant goes to the requester not served most recently. A single requester is granted immediately.

## Structure
- Shared `aes_pkg`:
  - FSM state typedef (IDLE/DATA/KEY).
  - `AES_STATE_W` = 128, `AES_WORD_W` = 32.
  - Word-index width.
- Sub-module `sbox_word`: four existing `sbox` instances mapping 32 → 32 bits bytewise. It is instantiated once here.

## Test plan
- Reset, then `d_in`=128'h000102030405060708090a0b0c0d0e0f → `d_out`=128'h637c777bf26b6fc53001672bfed7ab76 with `d_out_valid` 4 cycles after acceptance, pulsing exactly one cycle.
- `k_in`=32'hcf4f3c09 → `k_out`=32'h8a84eb01 with `k_out_valid` 1 cycle after acceptance.
- `d_valid` and `k_valid` both held high from reset, `d_in` all 8'h53 bytes, `k_in`=32'h00000000.
  - Round-robin build: data first (all 8'hed), then key (32'h63636363), alternating.
  - `SBOX_KEY_PRIO_EN` build: key is served repeatedly and data is starved while `k_valid` stays high.
- Raise `k_valid` during cycle 2 of a data job → `k_ready` stays low until the data job's completion cycle, and the data result is uncorrupted.
- Assert `rst` for one cycle in cycle 2 of a data job → no `d_out_valid`, `d_out`=0, and `busy`=0 the following cycle.
- Change `d_in` every cycle after acceptance → `d_out` reflects only the value present at acceptance.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, the S-box controller FSM states, and the
// GF(2^8) helpers used to build the byte S-box.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_WORD_W  = 32;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_WIDX_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_KEY  = 2'b10
  } share_state_e;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Forward AES S-box: field inverse followed by the affine transform.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/sbox.sv
// Single combinational AES forward S-box (one byte).
module sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] a,
  output logic [AES_BYTE_W-1:0] y
);

  assign y = sbox_fwd(a);

endmodule

// File: rtl/sbox_word.sv
// Bank of four S-boxes substituting a 32-bit word bytewise.
module sbox_word
  import aes_pkg::*;
(
  input  logic [AES_WORD_W-1:0] word_in,
  output logic [AES_WORD_W-1:0] word_out
);

  for (genvar g = 0; g < 4; g++) begin : g_byte
    sbox u_sbox (
      .a (word_in [g*AES_BYTE_W +: AES_BYTE_W]),
      .y (word_out[g*AES_BYTE_W +: AES_BYTE_W])
    );
  end

endmodule

// File: rtl/sbox_share_ctrl.sv
// Time-shares one 32-bit S-box bank between SubBytes (128-bit, four words)
// and SubWord (32-bit) requesters. Jobs are atomic and the results are
// registered with a one-cycle valid pulse.
// Build option SBOX_KEY_PRIO_EN: key requests win every tie (strict priority);
// otherwise ties are resolved round-robin, data first after reset.
module sbox_share_ctrl
  import aes_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [DATA_W-1:0] d_in,
  output logic              d_out_valid,
  output logic [DATA_W-1:0] d_out,
  input  logic              k_valid,
  output logic              k_ready,
  input  logic [WORD_W-1:0] k_in,
  output logic              k_out_valid,
  output logic [WORD_W-1:0] k_out,
  output logic              busy
);

  share_state_e           state_r;
  share_state_e           state_nx_s;
  logic [AES_WIDX_W-1:0]  cnt_r;
  logic [AES_WIDX_W-1:0]  cnt_nx_s;
  logic                   grant_d_s;
  logic                   grant_k_s;
  logic                   done_d_s;
  logic                   done_k_s;
  logic [DATA_W-1:0]      d_buf_r;
  logic [WORD_W-1:0]      k_buf_r;
  logic [DATA_W-1:0]      d_acc_r;
  logic [DATA_W-1:0]      d_acc_nx_s;
  logic [DATA_W-1:0]      d_out_r;
  logic [WORD_W-1:0]      k_out_r;
  logic                   d_out_valid_r;
  logic                   k_out_valid_r;
  logic [WORD_W-1:0]      bank_in_s;
  logic [WORD_W-1:0]      bank_out_s;

`ifndef SBOX_KEY_PRIO_EN
  logic                   last_key_r;
`endif

  // Arbitration: grants are only issued in IDLE, and never both at once.
  always_comb begin
    grant_d_s = 1'b0;
    grant_k_s = 1'b0;
    if (state_r == ST_IDLE) begin
`ifdef SBOX_KEY_PRIO_EN
      grant_k_s = k_valid;
      grant_d_s = d_valid & ~k_valid;
`else
      if (d_valid && k_valid) begin
        grant_d_s = last_key_r;
        grant_k_s = ~last_key_r;
      end else begin
        grant_d_s = d_valid;
        grant_k_s = k_valid;
      end
`endif
    end else begin
      grant_d_s = 1'b0;
      grant_k_s = 1'b0;
    end
  end

  assign d_ready = grant_d_s;
  assign k_ready = grant_k_s;

  assign done_d_s = (state_r == ST_DATA) && (cnt_r == 2'd3);
  assign done_k_s = (state_r == ST_KEY);

  // FSM state and word counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next-state logic: data walks four words, key takes a single cycle.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_d_s) begin
          state_nx_s = ST_DATA;
          cnt_nx_s   = 2'd0;
        end else if (grant_k_s) begin
          state_nx_s = ST_KEY;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (cnt_r == 2'd3) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = 2'd0;
        end else begin
          cnt_nx_s   = cnt_r + 2'd1;
        end
      end
      ST_KEY: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = 2'd0;
      end
    endcase
  end

  // Bank input select: current data word (word 0 is the MSW) or the key word.
  always_comb begin
    bank_in_s = 32'h0000_0000;
    case (state_r)
      ST_DATA: begin
        case (cnt_r)
          2'd0:    bank_in_s = d_buf_r[127:96];
          2'd1:    bank_in_s = d_buf_r[95:64];
          2'd2:    bank_in_s = d_buf_r[63:32];
          2'd3:    bank_in_s = d_buf_r[31:0];
          default: bank_in_s = 32'h0000_0000;
        endcase
      end
      ST_KEY:  bank_in_s = k_buf_r;
      default: bank_in_s = 32'h0000_0000;
    endcase
  end

  sbox_word u_bank (
    .word_in  (bank_in_s),
    .word_out (bank_out_s)
  );

  // Drop the bank output into the word slot being processed.
  always_comb begin
    d_acc_nx_s = d_acc_r;
    case (cnt_r)
      2'd0:    d_acc_nx_s[127:96] = bank_out_s;
      2'd1:    d_acc_nx_s[95:64]  = bank_out_s;
      2'd2:    d_acc_nx_s[63:32]  = bank_out_s;
      2'd3:    d_acc_nx_s[31:0]   = bank_out_s;
      default: d_acc_nx_s         = d_acc_r;
    endcase
  end

  // Input capture at acceptance, result assembly and registered outputs.
  // d_out only changes on completion so consumers never see a partial state.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_buf_r       <= 128'h0;
      k_buf_r       <= 32'h0;
      d_acc_r       <= 128'h0;
      d_out_r       <= 128'h0;
      k_out_r       <= 32'h0;
      d_out_valid_r <= 1'b0;
      k_out_valid_r <= 1'b0;
    end else begin
      d_out_valid_r <= done_d_s;
      k_out_valid_r <= done_k_s;
      if (grant_d_s) begin
        d_buf_r <= d_in;
      end
      if (grant_k_s) begin
        k_buf_r <= k_in;
      end
      if (state_r == ST_DATA) begin
        d_acc_r <= d_acc_nx_s;
      end
      if (done_d_s) begin
        d_out_r <= d_acc_nx_s;
      end
      if (done_k_s) begin
        k_out_r <= bank_out_s;
      end
    end
  end

`ifndef SBOX_KEY_PRIO_EN
  // Round-robin pointer: remembers whether the key side was served last.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_key_r <= 1'b1;
    end else if (grant_d_s) begin
      last_key_r <= 1'b0;
    end else if (grant_k_s) begin
      last_key_r <= 1'b1;
    end else begin
      last_key_r <= last_key_r;
    end
  end
`endif

  assign d_out       = d_out_r;
  assign k_out       = k_out_r;
  assign d_out_valid = d_out_valid_r;
  assign k_out_valid = k_out_valid_r;
  assign busy        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed self-checking bench for sbox_share_ctrl.
module tb_sbox_share_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         d_valid;
  logic         d_ready;
  logic [127:0] d_in;
  logic         d_out_valid;
  logic [127:0] d_out;
  logic         k_valid;
  logic         k_ready;
  logic [31:0]  k_in;
  logic         k_out_valid;
  logic [31:0]  k_out;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] VEC_IN  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VEC_OUT = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] ALL53   = {16{8'h53}};
  localparam logic [127:0] ALLED   = {16{8'hed}};
  localparam logic [31:0]  KEY_IN  = 32'hcf4f3c09;
  localparam logic [31:0]  KEY_OUT = 32'h8a84eb01;

  always #5 clk = ~clk;

  sbox_share_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d_in        (d_in),
    .d_out_valid (d_out_valid),
    .d_out       (d_out),
    .k_valid     (k_valid),
    .k_ready     (k_ready),
    .k_in        (k_in),
    .k_out_valid (k_out_valid),
    .k_out       (k_out),
    .busy        (busy)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_d(output int lat);
    lat = 0;
    while (d_out_valid !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_k(output int lat);
    lat = 0;
    while (k_out_valid !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bad;
    int n_ev;
    int d_pulses;
    int ev[4];
    int ev_exp[4];

    rst = 1'b1; d_valid = 1'b0; k_valid = 1'b0; d_in = 128'h0; k_in = 32'h0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_busy", busy, 0);
    check_eq("rst_d_out", d_out, 0);
    check_eq("rst_k_out", k_out, 0);
    check_eq("rst_d_out_valid", d_out_valid, 0);
    check_eq("rst_k_out_valid", k_out_valid, 0);
    check_eq("rst_ready", {d_ready, k_ready}, 0);

    // SubBytes on the FIPS-197 test vector, latency 4, one-cycle pulse
    d_valid = 1'b1; d_in = VEC_IN; #1;
    check_eq("d_ready_idle", d_ready, 1);
    check_eq("k_ready_idle", k_ready, 0);
    tick();
    d_valid = 1'b0;
    check_eq("busy_data", busy, 1);
    wait_d(lat);
    check_eq("d_latency", lat, 4);
    check_eq("d_out_vec", d_out, VEC_OUT);
    check_eq("busy_done", busy, 0);
    tick();
    check_eq("d_pulse_width", d_out_valid, 0);
    check_eq("d_out_hold", d_out, VEC_OUT);

    // Inputs scrambled every cycle after acceptance must not matter
    d_valid = 1'b1; d_in = ALL53; #1;
    tick();
    d_valid = 1'b0;
    lat = 0;
    while (d_out_valid !== 1'b1 && lat < 12) begin
      d_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
      lat++;
    end
    check_eq("scramble_latency", lat, 4);
    check_eq("scramble_d_out", d_out, ALLED);

    // SubWord, latency 1
    k_valid = 1'b1; k_in = KEY_IN; #1;
    check_eq("k_ready_only", {d_ready, k_ready}, 2'b01);
    tick();
    k_valid = 1'b0;
    wait_k(lat);
    check_eq("k_latency", lat, 1);
    check_eq("k_out_vec", k_out, KEY_OUT);
    check_eq("d_out_kept", d_out, ALLED);
    tick();
    check_eq("k_pulse_width", k_out_valid, 0);

    // Key request arriving mid data job must wait
    d_valid = 1'b1; d_in = VEC_IN; #1;
    tick();
    d_valid = 1'b0;
    tick();
    k_valid = 1'b1; k_in = KEY_IN; #1;
    bad = 0; lat = 0;
    while (d_out_valid !== 1'b1 && lat < 12) begin
      if (k_ready) bad++;
      tick();
      lat++;
    end
    check_eq("k_ready_blocked", bad, 0);
    check_eq("atomic_d_valid", d_out_valid, 1);
    check_eq("k_ready_at_done", k_ready, 1);
    check_eq("atomic_d_out", d_out, VEC_OUT);
    tick();
    k_valid = 1'b0;
    wait_k(lat);
    check_eq("late_k_latency", lat, 1);
    check_eq("late_k_out", k_out, KEY_OUT);

    // Reset in cycle 2 of a data job aborts it
    d_valid = 1'b1; d_in = ALL53; #1;
    tick();
    d_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_d_out", d_out, 0);
    check_eq("abort_d_valid", d_out_valid, 0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (d_out_valid) bad++;
    end
    check_eq("abort_no_pulse", bad, 0);

    // Both requesters held from reset
    rst = 1'b1; d_valid = 1'b1; k_valid = 1'b1; d_in = ALL53; k_in = 32'h0;
    tick(); tick();
    rst = 1'b0;
`ifdef SBOX_KEY_PRIO_EN
    ev_exp = '{2, 2, 2, 2};
`else
    ev_exp = '{1, 2, 1, 2};
`endif
    n_ev = 0; d_pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (d_out_valid) begin
        d_pulses++;
        check_eq("tie_d_out", d_out, ALLED);
        if (n_ev < 4) begin ev[n_ev] = 1; n_ev++; end
      end
      if (k_out_valid) begin
        check_eq("tie_k_out", k_out, 32'h63636363);
        if (n_ev < 4) begin ev[n_ev] = 2; n_ev++; end
      end
    end
    check_eq("tie_events", n_ev, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("tie_order_%0d", i), (i < n_ev) ? ev[i] : 0, ev_exp[i]);
    end
`ifdef SBOX_KEY_PRIO_EN
    check_eq("prio_data_starved", d_pulses, 0);
`endif
    d_valid = 1'b0; k_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
